// File: rtl/hc_pkg.sv
// Shared types and constants for the host-channel requestor stages.
// The CCI-P channel-1 structures are reduced to the fields this block uses.
package hc_pkg;

  localparam int HC_BUFFER_TX_DEPTH      = 8;
  localparam int HC_WR_OUTSTANDING_W     = 7;
  localparam int HC_WR_MAX_OUTSTANDING   = 64;
  localparam int HC_WR_RSP_DRAIN_CYCLES  = 64;
  localparam logic [15:0] HC_DSM_DONE_MDATA = 16'hFFFF;

  typedef logic [31:0] t_hc_control;
  localparam t_hc_control HC_CONTROL_ASSERT_RST   = 32'h0000_0000;
  localparam t_hc_control HC_CONTROL_DEASSERT_RST = 32'h0000_0001;
  localparam t_hc_control HC_CONTROL_START        = 32'h0000_0003;
  localparam t_hc_control HC_CONTROL_STOP         = 32'h0000_0007;

  typedef logic [63:0] t_hc_address;

  typedef struct packed {
    t_hc_address address;
    logic [31:0] size;
  } t_hc_buffer;

  typedef enum logic [1:0] {
    e_REQUEST_NONE          = 2'd0,
    e_REQUEST_WRITE_STREAM  = 2'd1,
    e_REQUEST_WRITE_INDEXED = 2'd2,
    e_REQUEST_READ          = 2'd3
  } t_request_cmd;

  typedef struct packed {
    t_request_cmd      cmd;
    logic [7:0]        id;
    logic [31:0]       offset;
    logic [15:0][31:0] data;
  } t_request_write_fifo;

  typedef enum logic [1:0] {
    S_WR_IDLE,
    S_WR_SEND,
    S_WR_FINISH_1,
    S_WR_FINISH_2
  } t_wr_state;

  typedef logic [41:0] t_ccip_clAddr;
  typedef logic [15:0] t_ccip_mdata;

  typedef enum logic [3:0] {
    eREQ_WRLINE_I = 4'h0,
    eREQ_WRLINE_M = 4'h1,
    eREQ_WRFENCE  = 4'h4
  } t_ccip_c1_req;

  typedef enum logic [1:0] {
    eCL_LEN_1 = 2'b00,
    eCL_LEN_2 = 2'b01,
    eCL_LEN_4 = 2'b11
  } t_ccip_clLen;

  typedef enum logic [1:0] {
    eVC_VA  = 2'b00,
    eVC_VL0 = 2'b01,
    eVC_VH0 = 2'b10,
    eVC_VH1 = 2'b11
  } t_ccip_vc;

  typedef enum logic [3:0] {
    eRSP_WRLINE  = 4'h1,
    eRSP_WRFENCE = 4'h4,
    eRSP_INTR    = 4'h8
  } t_ccip_c1_rsp;

  typedef struct packed {
    t_ccip_vc     vc_sel;
    logic         sop;
    t_ccip_clLen  cl_len;
    t_ccip_c1_req req_type;
    t_ccip_clAddr address;
    t_ccip_mdata  mdata;
  } t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    logic [511:0]       data;
    logic               valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    t_ccip_c1_rsp resp_type;
    t_ccip_mdata  mdata;
  } t_ccip_c1_RspMemHdr;

  typedef struct packed {
    t_ccip_c1_RspMemHdr hdr;
    logic               rspValid;
  } t_if_ccip_c1_Rx;

  function automatic t_ccip_c1_ReqMemHdr hc_wr_hdr(input t_ccip_clAddr address,
                                                   input t_ccip_mdata  mdata);
    t_ccip_c1_ReqMemHdr h;
    h          = '0;
    h.vc_sel   = eVC_VA;
    h.sop      = 1'b1;
    h.cl_len   = eCL_LEN_1;
    h.req_type = eREQ_WRLINE_I;
    h.address  = address;
    h.mdata    = mdata;
    return h;
  endfunction

endpackage

// File: rtl/hc_wr_requestor_if.sv
// Write-FIFO handshake plus CCI-P channel 1; master is the requestor side.
interface hc_wr_requestor_if;
  import hc_pkg::*;

  logic                wr_valid;
  logic                wr_ready;
  t_request_write_fifo wr_data;
  logic                c1TxAlmFull;
  t_if_ccip_c1_Tx      c1_tx;
  t_if_ccip_c1_Rx      c1_rx;

  modport master (
    input  wr_valid, wr_data, c1TxAlmFull, c1_rx,
    output wr_ready, c1_tx
  );

  modport slave (
    output wr_valid, wr_data, c1TxAlmFull, c1_rx,
    input  wr_ready, c1_tx
  );

endinterface

// File: rtl/hc_wr_fifo.sv
// Single-clock synchronous FIFO; depth must be a power of two so the
// pointers wrap naturally.
module hc_wr_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/hc_wr_requestor.sv
// Write-side requestor: buffers accelerator write requests, maps them onto
// physical cache lines, issues them on CCI-P c1 and ends with a DSM line.
//
// state          | meaning
// S_WR_IDLE      | waiting for START
// S_WR_SEND      | popping FIFO entries and issuing lines
// S_WR_FINISH_1  | STOP seen, waiting for outstanding writes to drain
// S_WR_FINISH_2  | DSM line issued; wr_done once it is acknowledged
module hc_wr_requestor #(
  parameter int HC_BUFFER_TX_DEPTH = hc_pkg::HC_BUFFER_TX_DEPTH,
  parameter int HC_BUFFER_SIZE     = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  hc_pkg::t_hc_control      hc_control_i,
  input  hc_pkg::t_hc_address      hc_dsm_base_i,
  input  hc_pkg::t_hc_buffer       hc_buffer_i [HC_BUFFER_SIZE],
  hc_wr_requestor_if.master        bus,
  output logic [hc_pkg::HC_WR_OUTSTANDING_W-1:0] wr_outstanding_o,
  output logic                     wr_error_o,
  output logic                     wr_done_o
);
  import hc_pkg::*;

  localparam int IDX_W = (HC_BUFFER_SIZE > 1) ? $clog2(HC_BUFFER_SIZE) : 1;
  localparam int CNT_W = $clog2(HC_BUFFER_TX_DEPTH) + 1;
  localparam int OW    = HC_WR_OUTSTANDING_W;

  t_wr_state           state_q, state_d;
  t_if_ccip_c1_Tx      tx_q, tx_d;
  logic [OW-1:0]       outstanding_q, outstanding_d;
  logic [31:0]         line_cnt_q;
  logic [OW-1:0]       drain_q;
  logic                error_q, error_d, done_q, done_d;

  logic                clear;
  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]    fifo_count;
  logic [$bits(t_request_write_fifo)-1:0] pop_bits;
  t_request_write_fifo pop_entry;
  logic                id_ok, in_range;
  logic [IDX_W-1:0]    buf_idx;
  t_hc_buffer          sel_buf;
  logic                issue_line, issue_dsm, issue, rsp_wr, rsp_dec;

  // Soft clear behaves like reset but leaves the FIFO contents alone
  assign clear = !reset_n || (hc_control_i == HC_CONTROL_ASSERT_RST);

  assign fifo_push = bus.wr_valid && !fifo_full &&
                     (bus.wr_data.cmd == e_REQUEST_WRITE_STREAM ||
                      bus.wr_data.cmd == e_REQUEST_WRITE_INDEXED);
  assign bus.wr_ready = !fifo_full;

  hc_wr_fifo #(
    .WIDTH ($bits(t_request_write_fifo)),
    .DEPTH (HC_BUFFER_TX_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .push_i  (fifo_push),
    .data_i  (bus.wr_data),
    .pop_i   (fifo_pop),
    .data_o  (pop_bits),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign pop_entry = t_request_write_fifo'(pop_bits);
  assign id_ok     = 32'(pop_entry.id) < HC_BUFFER_SIZE;
  assign buf_idx   = id_ok ? pop_entry.id[IDX_W-1:0] : '0;
  assign sel_buf   = hc_buffer_i[buf_idx];
  assign in_range  = id_ok && (pop_entry.offset < sel_buf.size);

  always_comb begin
    state_d    = state_q;
    fifo_pop   = 1'b0;
    issue_line = 1'b0;
    issue_dsm  = 1'b0;
    case (state_q)
      S_WR_IDLE: begin
        if (hc_control_i == HC_CONTROL_START) state_d = S_WR_SEND;
      end
      S_WR_SEND: begin
        if (!clear && !fifo_empty && !bus.c1TxAlmFull &&
            outstanding_q != OW'(HC_WR_MAX_OUTSTANDING)) begin
          fifo_pop   = 1'b1;
          issue_line = in_range;
        end
        if (hc_control_i == HC_CONTROL_STOP && fifo_count == '0) state_d = S_WR_FINISH_1;
      end
      S_WR_FINISH_1: begin
        if (outstanding_q == '0 && !bus.c1TxAlmFull) begin
          issue_dsm = 1'b1;
          state_d   = S_WR_FINISH_2;
        end
      end
      S_WR_FINISH_2: ;
      default: state_d = S_WR_IDLE;
    endcase
  end

  assign issue = issue_line || issue_dsm;
  // Responses during the post-reset window belong to a previous run
  assign rsp_wr  = bus.c1_rx.rspValid && (bus.c1_rx.hdr.resp_type == eRSP_WRLINE) &&
                   (drain_q == '0);
  assign rsp_dec = rsp_wr && (outstanding_q != '0);

  always_comb begin
    outstanding_d = outstanding_q;
    if (issue && !rsp_dec) outstanding_d = outstanding_q + 1'b1;
    else if (!issue && rsp_dec) outstanding_d = outstanding_q - 1'b1;
    error_d = error_q || (fifo_pop && !in_range) || (rsp_wr && outstanding_q == '0);
    done_d  = done_q || (state_q == S_WR_FINISH_2 && rsp_wr &&
                         bus.c1_rx.hdr.mdata == HC_DSM_DONE_MDATA);
  end

  always_comb begin
    tx_d = '0;
    if (issue_line) begin
      tx_d.valid = 1'b1;
      tx_d.hdr   = hc_wr_hdr(sel_buf.address[41:0] + t_ccip_clAddr'(pop_entry.offset),
                             line_cnt_q[15:0]);
      tx_d.data  = pop_entry.data;
    end else if (issue_dsm) begin
      tx_d.valid       = 1'b1;
      tx_d.hdr         = hc_wr_hdr(hc_dsm_base_i[41:0], HC_DSM_DONE_MDATA);
      tx_d.data[31:0]  = 32'd1;
      tx_d.data[63:32] = line_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q       <= S_WR_IDLE;
      tx_q          <= '0;
      outstanding_q <= '0;
      line_cnt_q    <= '0;
      error_q       <= 1'b0;
      done_q        <= 1'b0;
      drain_q       <= OW'(HC_WR_RSP_DRAIN_CYCLES);
    end else begin
      state_q       <= state_d;
      tx_q          <= tx_d;
      outstanding_q <= outstanding_d;
      error_q       <= error_d;
      done_q        <= done_d;
      if (issue_line) line_cnt_q <= line_cnt_q + 32'd1;
      if (drain_q != '0) drain_q <= drain_q - 1'b1;
    end
  end

  assign bus.c1_tx        = tx_q;
  assign wr_outstanding_o = outstanding_q;
  assign wr_error_o       = error_q;
  assign wr_done_o        = done_q;

  logic unused_bits;
  assign unused_bits = ^{hc_dsm_base_i[63:42], sel_buf.address[63:42], pop_entry.cmd};

endmodule
